sliding_window_gen: RTL
=======================

SLIDING_WINDOW_GEN -- requirements
Module: sliding_window_gen

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8: pixel width in bits.
REQ-002 SHALL have parameter ROW_SIZE, default 28: pixels per image row.
REQ-003 SHALL have parameter COL_SIZE, default 28: rows per frame.
REQ-004 SHALL have parameter KERNEL_SIZE, default 3: window edge K, legal range 2..7.
REQ-005 SHALL have parameter STRIDE, default 1: window step in both axes, legal range 1..K.
REQ-006 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port in_valid, input, 1: data_in carries a pixel.
REQ-009 SHALL have port in_ready, output, 1: the block accepts a pixel this cycle.
REQ-010 SHALL have port data_in, input, DATA_SIZE: pixel, raster order.
REQ-011 SHALL have port out_valid, output, 1: window_out holds a valid window.
REQ-012 SHALL have port out_ready, input, 1: the consumer takes the window.
REQ-013 SHALL have port window_out, output, K*K*DATA_SIZE: element (r,c) at bits [(r*K+c)*DATA_SIZE +: DATA_SIZE]; r=0 is the oldest row, c=0 the oldest column.
REQ-014 SHALL have port frame_done, output, 1: one-cycle pulse.

Function
REQ-015 SHALL define accept as in_valid && in_ready, and SHALL drive in_ready = !out_valid || out_ready (combinational).
REQ-016 SHALL keep col (0..ROW_SIZE-1) and row (0..COL_SIZE-1) counters, advancing only on accept; col wraps to 0 and increments row at ROW_SIZE-1; both wrap to 0 after pixel (COL_SIZE-1, ROW_SIZE-1).
REQ-017 SHALL hold K-1 row delays of ROW_SIZE entries, so each accepted pixel yields a K-high column (current pixel plus same-column pixels from the K-1 previous rows).
REQ-018 SHALL shift that column into a K x K register window on every accept, with the newest column at c=K-1.
REQ-019 SHALL mark an accept as emitting when col>=K-1, row>=K-1, (col-(K-1))%STRIDE==0 and (row-(K-1))%STRIDE==0.
REQ-020 SHALL register out_valid high on the cycle after an emitting accept (latency 1), with window_out holding that window.
REQ-021 SHALL hold out_valid and window_out stable while out_valid && !out_ready.
REQ-022 SHALL clear out_valid after a cycle with out_valid && out_ready, unless the same cycle contains an emitting accept, in which case out_valid stays high and window_out takes the new window.
REQ-023 SHALL never emit a window that spans a row wrap or a frame boundary.
REQ-024 SHALL pulse frame_done for one cycle, the cycle after the last pixel of a frame is accepted.
REQ-025 SHALL ignore data_in when in_valid is low or in_ready is low, with no counter or storage change.
REQ-026 SHALL emit exactly ((ROW_SIZE-K)/STRIDE+1)*((COL_SIZE-K)/STRIDE+1) windows per frame, using integer division.

Reset
REQ-027 SHALL on reset_n low clear col, row, out_valid and frame_done to 0, drive window_out to 0, and drop any pending window.
REQ-028 SHALL require no reset of the row-delay storage; stale contents are never emitted because of REQ-019.
REQ-029 SHALL, after reset mid-frame, treat the next accepted pixel as (row 0, col 0) of a new frame.

Structure
REQ-030 SHALL place the default DATA_SIZE, KERNEL_SIZE and STRIDE constants and a window-index helper function (r,c -> bit offset) in shared package cnn_pkg.
REQ-031 SHALL implement each row delay as sub-module row_delay (ROW_SIZE-deep, DATA_SIZE-wide, advancing on enable, inferable as RAM), instantiated K-1 times.

Verification (default parameters unless stated; data_in = i mod 256 for pixel index i)
REQ-032 Bench SHALL stream 784 pixels continuously with out_ready=1 -> first out_valid one cycle after pixel 58; that window has (0,0)=0, (0,2)=2, (2,0)=56, (2,2)=58; 676 windows total; one frame_done.
REQ-033 Bench SHALL repeat with STRIDE=2 -> 169 windows; the first ends at pixel 58 and the second at pixel 60.
REQ-034 Bench SHALL hold out_ready=0 for 5 cycles at the first window -> in_ready=0 and window_out stable for 5 cycles; resumes with no pixel lost and 676 windows total.
REQ-035 Bench SHALL drive in_valid with a random 50% duty -> window contents identical to REQ-032, in order.
REQ-036 Bench SHALL assert reset_n low after pixel 100, then stream a full frame -> out_valid=0 during reset; new frame matches REQ-032 exactly.
REQ-037 Bench SHALL stream two back-to-back frames -> no window spans the frame boundary; 2 frame_done pulses and 1352 windows.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN front-end constants and the window packing helper.
// Every block that packs or unpacks a K x K window uses win_offset.
package cnn_pkg;

  localparam int DEF_DATA_SIZE   = 8;
  localparam int DEF_KERNEL_SIZE = 3;
  localparam int DEF_STRIDE      = 1;

  // Element (r,c) of a K x K window lives at this bit offset; r=0 oldest row, c=0 oldest column.
  function automatic int win_offset(input int r, input int c, input int k, input int dw);
    return (r * k + c) * dw;
  endfunction

endpackage

// File: rtl/sliding_window_gen_if.sv
// Pixel-in / window-out handshake bundle for sliding_window_gen.
// The master side is the pixel source and window consumer.
interface sliding_window_gen_if
  import cnn_pkg::*;
#(
  parameter int DATA_SIZE   = DEF_DATA_SIZE,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE
) (
  input logic clock
);

  logic                                          in_valid;
  logic                                          in_ready;
  logic [DATA_SIZE-1:0]                          data_in;
  logic                                          out_valid;
  logic                                          out_ready;
  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_SIZE-1:0]  window_out;
  logic                                          frame_done;

  modport master (
    input  clock, in_ready, out_valid, window_out, frame_done,
    output in_valid, data_in, out_ready
  );

  modport slave (
    input  clock, in_valid, data_in, out_ready,
    output in_ready, out_valid, window_out, frame_done
  );

endinterface

// File: rtl/row_delay.sv
// One image row of delay: dout is the value written DEPTH enables ago.
// Storage is left unreset so it maps onto RAM; the read is combinational.
module row_delay #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    ptr_r;

  assign dout = mem_r[ptr_r];

  // Circular pointer; the slot it addresses is read out and then overwritten.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r <= '0;
    end else if (en) begin
      ptr_r <= (ptr_r == AW'(DEPTH - 1)) ? '0 : ptr_r + AW'(1);
    end
  end

  // Delay storage write.
  always_ff @(posedge clock) begin
    if (en) begin
      mem_r[ptr_r] <= din;
    end
  end

endmodule

// File: rtl/sliding_window_gen.sv
// Raster-order pixel stream to K x K sliding windows with stride, valid/ready on both sides.
// K-1 row delays form a column per pixel; a column shift register forms the window.
module sliding_window_gen
  import cnn_pkg::*;
#(
  parameter int DATA_SIZE   = DEF_DATA_SIZE,
  parameter int ROW_SIZE    = 28,
  parameter int COL_SIZE    = 28,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int STRIDE      = DEF_STRIDE
) (
  input  logic                                         clock,
  input  logic                                         reset_n,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [DATA_SIZE-1:0]                         data_in,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_SIZE-1:0] window_out,
  output logic                                         frame_done
);

  localparam int CW  = $clog2(ROW_SIZE);
  localparam int RW  = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam int KM1 = KERNEL_SIZE - 1;
  localparam int WW  = KERNEL_SIZE * KERNEL_SIZE * DATA_SIZE;

  logic [CW-1:0]        col_r;
  logic [RW-1:0]        row_r;
  logic                 out_valid_r;
  logic [WW-1:0]        window_r;
  logic                 frame_done_r;
  logic [DATA_SIZE-1:0] win_r      [KERNEL_SIZE][KERNEL_SIZE];
  logic [DATA_SIZE-1:0] win_next_s [KERNEL_SIZE][KERNEL_SIZE];
  logic [DATA_SIZE-1:0] tap_s      [KERNEL_SIZE];
  logic [WW-1:0]        win_flat_s;
  logic                 accept_s;
  logic                 col_hit_s;
  logic                 row_hit_s;
  logic                 emit_s;
  logic                 last_s;

  assign in_ready   = !out_valid_r || out_ready;
  assign accept_s   = in_valid && in_ready;
  assign out_valid  = out_valid_r;
  assign window_out = window_r;
  assign frame_done = frame_done_r;

  // tap_s[j] is the pixel j rows above the incoming one, same column.
  assign tap_s[0] = data_in;

  for (genvar j = 0; j < KM1; j++) begin : g_row_delay
    row_delay #(
      .DEPTH (ROW_SIZE),
      .WIDTH (DATA_SIZE)
    ) u_row_delay (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (accept_s),
      .din     (tap_s[j]),
      .dout    (tap_s[j+1])
    );
  end

  // Emission decode: full window in bounds and on the stride grid of both axes.
  always_comb begin
    col_hit_s = 1'b0;
    row_hit_s = 1'b0;
    if (32'(col_r) >= 32'(KM1)) begin
      col_hit_s = ((32'(col_r) - 32'(KM1)) % 32'(STRIDE)) == 32'd0;
    end else begin
      col_hit_s = 1'b0;
    end
    if (32'(row_r) >= 32'(KM1)) begin
      row_hit_s = ((32'(row_r) - 32'(KM1)) % 32'(STRIDE)) == 32'd0;
    end else begin
      row_hit_s = 1'b0;
    end
    emit_s = accept_s && col_hit_s && row_hit_s;
    last_s = accept_s && (col_r == CW'(ROW_SIZE - 1)) && (row_r == RW'(COL_SIZE - 1));
  end

  // Next window: shift columns toward c=0 and drop the new column in at c=K-1, oldest row first.
  always_comb begin
    win_flat_s = '0;
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      for (int c = 0; c < KM1; c++) begin
        win_next_s[r][c] = win_r[r][c+1];
      end
      win_next_s[r][KM1] = tap_s[KM1-r];
      for (int c = 0; c < KERNEL_SIZE; c++) begin
        win_flat_s[win_offset(r, c, KERNEL_SIZE, DATA_SIZE) +: DATA_SIZE] = win_next_s[r][c];
      end
    end
  end

  // Position counters, window shift register and the registered output stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_r        <= '0;
      row_r        <= '0;
      out_valid_r  <= 1'b0;
      window_r     <= '0;
      frame_done_r <= 1'b0;
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE; c++) begin
          win_r[r][c] <= '0;
        end
      end
    end else begin
      frame_done_r <= last_s;
      if (accept_s) begin
        win_r <= win_next_s;
        if (col_r == CW'(ROW_SIZE - 1)) begin
          col_r <= '0;
          row_r <= (row_r == RW'(COL_SIZE - 1)) ? '0 : row_r + RW'(1);
        end else begin
          col_r <= col_r + CW'(1);
        end
      end
      // A taken window may be replaced by a new one in the same cycle.
      if (emit_s) begin
        out_valid_r <= 1'b1;
        window_r    <= win_flat_s;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule
